// File: rtl/handshaking_pkg.sv
// Shared definitions for the valid/ready byte link (master and slave ends).
package handshaking_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int RX_CNT_W   = 16;

    typedef logic [DEF_DATA_W-1:0] word_t;

endpackage : handshaking_pkg

// File: rtl/hs_fifo_mem.sv
// Buffer storage for handshaking_slave: one synchronous write port, one async read port.
module hs_fifo_mem #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_r [DEPTH];

    // Storage write; the array is deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule : hs_fifo_mem

// File: rtl/handshaking_slave.sv
// Receiving end of the valid/ready link: buffers accepted words in a FWFT FIFO
// and hands them to the local consumer on a second valid/ready pair.
module handshaking_slave
    import handshaking_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_W-1:0]          data_in,
    input  logic                       valid_in,
    output logic                       ready_out,
    output logic [DATA_W-1:0]          data_out,
    output logic                       data_valid,
    input  logic                       data_ready,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [RX_CNT_W-1:0]        rx_total
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0]       CNT_ONE = CW'(1);
    localparam logic [CW-1:0]       CNT_MAX = CW'(DEPTH);
    localparam logic [AW-1:0]       PTR_ONE = AW'(1);
    localparam logic [RX_CNT_W-1:0] RX_ONE  = RX_CNT_W'(1);

    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_nxt_s;
    logic          push_s;
    logic          pop_s;

    assign push_s     = valid_in && ready_out;
    assign pop_s      = data_valid && data_ready;
    assign data_valid = (count != {CW{1'b0}});

    // Next occupancy: a simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_nxt_s = count;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count + CNT_ONE;
            2'b01:   count_nxt_s = count - CNT_ONE;
            default: count_nxt_s = count;
        endcase
    end

    // Control state: pointers, occupancy, registered ready and receive counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r  <= {AW{1'b0}};
            rd_ptr_r  <= {AW{1'b0}};
            count     <= {CW{1'b0}};
            ready_out <= 1'b0;
            rx_total  <= {RX_CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
                rx_total <= rx_total + RX_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count <= count_nxt_s;
            // Ready looks one cycle ahead so the master is stopped before overflow.
            ready_out <= (count_nxt_s < CNT_MAX);
        end
    end

    hs_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_mem (
        .clk   (clk),
        .we    (push_s),
        .waddr (wr_ptr_r),
        .wdata (data_in),
        .raddr (rd_ptr_r),
        .rdata (data_out)
    );

endmodule : handshaking_slave

// File: tb/tb_handshaking_slave.sv
// Directed self-checking bench for handshaking_slave (DATA_W=8, DEPTH=4).
module tb_handshaking_slave;
    import handshaking_pkg::*;

    logic        clk;
    logic        rst;
    word_t       data_in;
    logic        valid_in;
    logic        ready_out;
    word_t       data_out;
    logic        data_valid;
    logic        data_ready;
    logic [2:0]  count;
    logic [15:0] rx_total;

    int n_cmp;
    int n_err;

    handshaking_slave #(
        .DATA_W (8),
        .DEPTH  (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .valid_in   (valid_in),
        .ready_out  (ready_out),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .count      (count),
        .rx_total   (rx_total)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        rst        = 1'b0;
        data_in    = 8'h00;
        valid_in   = 1'b0;
        data_ready = 1'b0;

        // Reset held for three edges, then released between edges.
        repeat (3) step();
        check_eq("rst_ready", {31'd0, ready_out}, 32'd0);
        check_eq("rst_count", {29'd0, count}, 32'd0);
        check_eq("rst_valid", {31'd0, data_valid}, 32'd0);
        check_eq("rst_total", {16'd0, rx_total}, 32'd0);
        rst = 1'b1;
        step();
        check_eq("rel_ready", {31'd0, ready_out}, 32'd1);
        check_eq("rel_count", {29'd0, count}, 32'd0);
        check_eq("rel_valid", {31'd0, data_valid}, 32'd0);

        // Single word.
        data_in  = 8'hA5;
        valid_in = 1'b1;
        step();
        valid_in = 1'b0;
        check_eq("one_valid", {31'd0, data_valid}, 32'd1);
        check_eq("one_data", {24'd0, data_out}, 32'hA5);
        check_eq("one_count", {29'd0, count}, 32'd1);
        check_eq("one_total", {16'd0, rx_total}, 32'd1);
        data_ready = 1'b1;
        step();
        data_ready = 1'b0;
        check_eq("one_pop_count", {29'd0, count}, 32'd0);
        check_eq("one_pop_valid", {31'd0, data_valid}, 32'd0);

        // Fill to DEPTH, then offer a fifth word that must be held off.
        valid_in = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            data_in = 8'(i);
            step();
        end
        check_eq("full_ready", {31'd0, ready_out}, 32'd0);
        check_eq("full_count", {29'd0, count}, 32'd4);
        data_in = 8'h05;
        step();
        check_eq("held_count", {29'd0, count}, 32'd4);
        check_eq("held_total", {16'd0, rx_total}, 32'd5);
        check_eq("held_head", {24'd0, data_out}, 32'h01);
        data_ready = 1'b1;
        step();
        data_ready = 1'b0;
        check_eq("freed_count", {29'd0, count}, 32'd3);
        check_eq("freed_ready", {31'd0, ready_out}, 32'd1);
        step();
        valid_in = 1'b0;
        check_eq("refill_count", {29'd0, count}, 32'd4);
        check_eq("refill_total", {16'd0, rx_total}, 32'd6);
        check_eq("refill_ready", {31'd0, ready_out}, 32'd0);
        data_ready = 1'b1;
        for (int k = 2; k <= 5; k++) begin
            check_eq("drain_valid", {31'd0, data_valid}, 32'd1);
            check_eq("drain_data", {24'd0, data_out}, 32'(k));
            step();
        end
        data_ready = 1'b0;
        check_eq("drain_count", {29'd0, count}, 32'd0);

        // Streaming: push and pop every cycle, occupancy stays at one.
        valid_in   = 1'b1;
        data_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            data_in = 8'h40 + 8'(i);
            step();
            check_eq("stream_count", {29'd0, count}, 32'd1);
            check_eq("stream_data", {24'd0, data_out}, 32'h40 + 32'(i));
        end
        valid_in = 1'b0;
        step();
        data_ready = 1'b0;
        check_eq("stream_empty", {29'd0, count}, 32'd0);
        check_eq("stream_total", {16'd0, rx_total}, 32'd26);

        // Reset asserted between edges with three words buffered.
        valid_in = 1'b1;
        data_in  = 8'h11; step();
        data_in  = 8'h22; step();
        data_in  = 8'h33; step();
        valid_in = 1'b0;
        check_eq("pre_rst_count", {29'd0, count}, 32'd3);
        #2;
        rst = 1'b0;
        #1;
        check_eq("mid_rst_count", {29'd0, count}, 32'd0);
        check_eq("mid_rst_valid", {31'd0, data_valid}, 32'd0);
        check_eq("mid_rst_ready", {31'd0, ready_out}, 32'd0);
        check_eq("mid_rst_total", {16'd0, rx_total}, 32'd0);
        step();
        rst = 1'b1;
        step();
        check_eq("post_rst_ready", {31'd0, ready_out}, 32'd1);
        data_in  = 8'h77;
        valid_in = 1'b1;
        step();
        valid_in = 1'b0;
        check_eq("post_rst_data", {24'd0, data_out}, 32'h77);
        check_eq("post_rst_count", {29'd0, count}, 32'd1);
        check_eq("post_rst_total", {16'd0, rx_total}, 32'd1);
        data_ready = 1'b1;
        step();
        data_ready = 1'b0;
        check_eq("post_rst_drain", {29'd0, count}, 32'd0);

        // Counter wrap: 65534 more pushes bring rx_total from 1 to 0xFFFF.
        valid_in   = 1'b1;
        data_ready = 1'b1;
        for (int i = 0; i < 65534; i++) begin
            data_in = 8'(i);
            step();
        end
        check_eq("wrap_max", {16'd0, rx_total}, 32'h0000FFFF);
        step();
        check_eq("wrap_zero", {16'd0, rx_total}, 32'd0);
        valid_in = 1'b0;
        step();
        data_ready = 1'b0;
        check_eq("wrap_empty", {29'd0, count}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_handshaking_slave
